// File: rtl/rcpu_io_uart_tx.sv
// RCPU IO-bus UART transmitter: TX FIFO, status and baud divisor registers,
// and an 8N1 serializer driving uart_tx.
module rcpu_io_uart_tx #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_read_enable,
    input  logic        io_write_enable,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0] ADDR_TX = BASE_ADDR;
    localparam logic [15:0] ADDR_ST = BASE_ADDR + 16'd1;
    localparam logic [15:0] ADDR_BD = BASE_ADDR + 16'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   bit_div_q, bit_div_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [15:0]   rdata_q, rdata_d;

    logic        sel_tx, sel_st, sel_bd;
    logic        push, push_ok, pop;
    logic        full, empty, busy, bit_end;
    logic [15:0] div_eff, status;

    assign sel_tx  = io_addr == ADDR_TX;
    assign sel_st  = io_addr == ADDR_ST;
    assign sel_bd  = io_addr == ADDR_BD;
    assign full    = count_q == FULL_CNT;
    assign empty   = count_q == '0;
    assign busy    = state_q != IDLE;
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_end = baud_cnt_q >= bit_div_q - 16'd1;
    assign push    = io_write_enable && sel_tx;
    assign push_ok = push && (!full || pop);
    assign status  = {{(8-CW){1'b0}}, count_q, 4'b0000,
                      overflow_q, busy, empty, full};

    // Each bit latches its own divisor so a mid-bit BAUDDIV write waits.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        bit_div_d  = bit_div_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_div_d = div_eff;
                    tx_d      = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_div_d  = div_eff;
                    bit_idx_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_div_d  = div_eff;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_div_d  = div_eff;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (io_read_enable && sel_st) begin
            overflow_d = 1'b0;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        div_d = (io_write_enable && sel_bd) ? io_write_data : div_q;
        rdata_d = rdata_q;
        if (io_read_enable) begin
            unique case (1'b1)
                sel_st:  rdata_d = status;
                sel_bd:  rdata_d = div_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= io_write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            div_q      <= DEFAULT_DIV;
            bit_div_q  <= 16'd1;
            baud_cnt_q <= '0;
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            rdata_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            bit_div_q  <= bit_div_d;
            baud_cnt_q <= baud_cnt_d;
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rdata_q    <= rdata_d;
        end
    end

    assign io_read_data = rdata_q;
    assign uart_tx      = tx_q;

endmodule

// File: tb/tb_rcpu_io_uart_tx.sv
// Directed bench for rcpu_io_uart_tx: register map, frame timing,
// FIFO overflow, mid-frame divisor change and reset.
module tb_rcpu_io_uart_tx;
    localparam logic [15:0] A_TX = 16'hFF00;
    localparam logic [15:0] A_ST = 16'hFF01;
    localparam logic [15:0] A_BD = 16'hFF02;

    logic        clk;
    logic        reset;
    logic        io_read_enable;
    logic        io_write_enable;
    logic [15:0] io_addr;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;
    logic        uart_tx;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [7:0]  fb [0:7];
    logic        tx_log [$];
    logic [15:0] st_log [$];
    logic [15:0] rd_val;

    rcpu_io_uart_tx dut (
        .clk             (clk),
        .reset           (reset),
        .io_read_enable  (io_read_enable),
        .io_write_enable (io_write_enable),
        .io_addr         (io_addr),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .uart_tx         (uart_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        io_write_enable = 1'b1;
        io_addr         = a;
        io_write_data   = d;
        @(negedge clk);
        io_write_enable = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        io_read_enable = 1'b1;
        io_addr        = a;
        @(negedge clk);
        io_read_enable = 1'b0;
        d              = io_read_data;
    endtask

    task automatic sample(input int n);
        tx_log.delete();
        st_log.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log.push_back(uart_tx);
            st_log.push_back(io_read_data);
        end
    endtask

    // t = cycles since the first start-bit cycle; frames from fb[].
    function automatic logic frame_bit(input int t, input int div,
                                       input int nb);
        int fr;
        int b;
        if (t < 0 || t >= 10 * div * nb) return 1'b1;
        fr = t / (10 * div);
        b  = (t % (10 * div)) / div;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return fb[fr][b-1];
    endfunction

    task automatic check_line(input string tag, input int j0,
                              input int div, input int nb);
        int bad = -1;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (bad < 0 && tx_log[i] !== frame_bit(j0 + i - 1, div, nb))
                bad = i;
        end
        check(tag, bad, -1);
    endtask

    initial begin
        int busy_n;
        int bad;
        logic exp_bit;
        logic [7:0] d5;

        reset           = 1'b1;
        io_read_enable  = 1'b0;
        io_write_enable = 1'b0;
        io_addr         = '0;
        io_write_data   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_rdata", io_read_data, 16'h0000);
        check("rst_tx", uart_tx, 1'b1);
        rd(A_ST, rd_val);
        check("rst_status", rd_val, 16'h0002);
        rd(A_BD, rd_val);
        check("rst_baud", rd_val, 16'd104);

        // single frame at divisor 4, status read held throughout
        wr(A_BD, 16'd4);
        rd(A_BD, rd_val);
        check("baud_rw", rd_val, 16'd4);
        fb[0] = 8'h55;
        wr(A_TX, 16'hAB55);
        check("tx_before_fall", uart_tx, 1'b1);
        io_read_enable = 1'b1;
        io_addr        = A_ST;
        sample(50);
        io_read_enable = 1'b0;
        check_line("frame_55", 1, 4, 1);
        busy_n = 0;
        foreach (st_log[i]) busy_n += int'(st_log[i][2]);
        check("busy_cycles", busy_n, 40);
        check("st_first", st_log[0], 16'h0100);
        check("st_idle_end", st_log[49], 16'h0002);

        // three back-to-back frames at divisor 2
        wr(A_BD, 16'd2);
        fb[0] = 8'h41;
        fb[1] = 8'h42;
        fb[2] = 8'h43;
        wr(A_TX, 16'h0041);
        wr(A_TX, 16'h0042);
        wr(A_TX, 16'h0043);
        io_read_enable = 1'b1;
        io_addr        = A_ST;
        sample(70);
        io_read_enable = 1'b0;
        check_line("frames_abc", 3, 2, 3);
        check("st_count2", st_log[0], 16'h0204);
        check("st_count1", st_log[38], 16'h0104);
        check("st_count0", st_log[39], 16'h0006);
        check("st_abc_idle", st_log[69], 16'h0002);

        // overflow: 10 writes while the first frame runs slowly
        wr(A_BD, 16'd1000);
        wr(A_TX, 16'h0000);
        for (int i = 1; i < 10; i++) wr(A_TX, 16'(8'h10 + i));
        rd(A_ST, rd_val);
        check("st_overflow", rd_val, 16'h080D);
        rd(A_ST, rd_val);
        check("st_ovf_clear", rd_val, 16'h0805);
        check("tx_start_slow", uart_tx, 1'b0);
        repeat (1500) @(negedge clk);
        check("tx_data0", uart_tx, 1'b0);

        // reset in the middle of the data bits
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_tx", uart_tx, 1'b1);
        check("mid_rst_rdata", io_read_data, 16'h0000);
        rd(A_ST, rd_val);
        check("mid_rst_status", rd_val, 16'h0002);
        rd(A_BD, rd_val);
        check("mid_rst_baud", rd_val, 16'd104);
        sample(2000);
        check_line("no_frame_after_rst", 1, 104, 0);

        // divisor 4 -> 8 during the start bit
        wr(A_BD, 16'd4);
        d5 = 8'h0F;
        wr(A_TX, {8'h00, d5});
        check("tx_before_fall2", uart_tx, 1'b1);
        @(negedge clk);
        wr(A_BD, 16'd8);
        sample(90);
        bad = -1;
        for (int i = 0; i < 90; i++) begin
            int t;
            t = i + 2;
            if (t < 4) exp_bit = 1'b0;
            else if (t < 68) exp_bit = d5[(t - 4) / 8];
            else exp_bit = 1'b1;
            if (bad < 0 && tx_log[i] !== exp_bit) bad = i;
        end
        check("baud_change", bad, -1);

        // unmapped addresses
        wr(16'hFF03, 16'h1234);
        wr(16'h0000, 16'h5555);
        rd(A_BD, rd_val);
        check("unmapped_baud", rd_val, 16'd8);
        rd(16'hFF03, rd_val);
        check("rd_ff03", rd_val, 16'h0000);
        rd(A_ST, rd_val);
        check("unmapped_status", rd_val, 16'h0002);
        rd(16'h0000, rd_val);
        check("rd_0000", rd_val, 16'h0000);
        rd(A_BD, rd_val);
        rd(A_TX, rd_val);
        check("rd_txdata", rd_val, 16'h0000);
        check("unmapped_tx", uart_tx, 1'b1);

        // divisor 0 behaves as 1
        wr(A_BD, 16'd0);
        rd(A_BD, rd_val);
        check("baud_zero_rd", rd_val, 16'd0);
        fb[0] = 8'hA5;
        wr(A_TX, 16'h00A5);
        sample(15);
        check_line("frame_div0", 1, 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
